// File: rtl/stream_demux4.sv
// stream_demux4 -- 1-to-4 valid/ready stream demultiplexer.
//
// Each input word is routed to the output channel selected by in_sel and held
// in that channel's single-entry register buffer until the channel sink takes
// it. Channels drain independently, so a stalled sink only back-pressures
// words addressed to its own channel.
//
// Ports
//   clk                      rising-edge clock for all state
//   rst_n                    asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_data[WIDTH-1:0]       input word
//   in_sel[1:0]              destination channel, sampled at the input handshake
//   outN_valid/outN_ready    per-channel output handshake, N = 0..3
//   outN_data[WIDTH-1:0]     per-channel buffered word
//   cnt0..cnt3[7:0]          per-channel output handshake counters, wrap at 255
//                            (present only with STREAM_DEMUX4_CNT_EN defined)
//
// Build option
//   STREAM_DEMUX4_CNT_EN     adds the cnt0..cnt3 ports and their counters
//
// Buffer state (one per channel)
//   state | meaning
//   EMPTY | no word held; outN_valid low, buffer may be loaded
//   FULL  | word held on outN_data; outN_valid high until the sink accepts it

module stream_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef STREAM_DEMUX4_CNT_EN
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out3_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t       state  [4];
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       out_ready_v;
  logic [3:0]       full_v;
  logic [3:0]       drain_v;
  logic [3:0]       load_v;
  logic             in_fire;

  assign out_ready_v = {out3_ready, out2_ready, out1_ready, out0_ready};

  // A full buffer whose sink is accepting this cycle frees its slot on the
  // same edge, so the selected channel can take a new word without a bubble.
  assign in_ready = ~full_v[in_sel] | out_ready_v[in_sel];
  assign in_fire  = in_valid & in_ready;
  assign load_v   = in_fire ? (4'b0001 << in_sel) : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    assign full_v[g]  = (state[g] == FULL);
    // outN_ready only matters while a word is held.
    assign drain_v[g] = full_v[g] & out_ready_v[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state[g]  <= EMPTY;
        data_q[g] <= '0;
      end else if (load_v[g]) begin
        state[g]  <= FULL;
        data_q[g] <= in_data;
      end else if (drain_v[g]) begin
        state[g]  <= EMPTY;
      end
    end
  end

  assign out0_valid = full_v[0];
  assign out1_valid = full_v[1];
  assign out2_valid = full_v[2];
  assign out3_valid = full_v[3];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];

`ifdef STREAM_DEMUX4_CNT_EN
  logic [7:0] cnt_q [4];

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (drain_v[g]) begin
        cnt_q[g] <= cnt_q[g] + 8'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4: reset state, routing, back-pressure,
// pass-through, channel independence, asynchronous reset and (when built with
// STREAM_DEMUX4_CNT_EN) the handshake counters.

module tb_stream_demux4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             out0_valid, out1_valid, out2_valid, out3_valid;
  logic             out0_ready, out1_ready, out2_ready, out3_ready;
  logic [WIDTH-1:0] out0_data, out1_data, out2_data, out3_data;
`ifdef STREAM_DEMUX4_CNT_EN
  logic [7:0]       cnt0, cnt1, cnt2, cnt3;
`endif

  int n_tests;
  int n_fail;

  stream_demux4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef STREAM_DEMUX4_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt3       (cnt3),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .out3_valid (out3_valid),
    .out3_ready (out3_ready),
    .out3_data  (out3_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] valids();
    return {28'b0, out3_valid, out2_valid, out1_valid, out0_valid};
  endfunction

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 2'd0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    out3_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_valids", valids(), 32'h0);
    chk("rst_data", {out3_data, out2_data, out1_data, out0_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Basic route to channel 2
    in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out2_ready = 1'b1;
    #1;
    chk("basic_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("basic_valids", valids(), 32'h4);
    chk("basic_data", 32'(out2_data), 32'hA5);
    step();
    chk("basic_drained", valids(), 32'h0);
    out2_ready = 1'b0;

    // Back-pressure on channel 1
    in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
    step();
    in_data = 8'h22;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("bp_hold_data", 32'(out1_data), 32'h11);
    chk("bp_hold_valid", 32'(out1_valid), 32'h1);
    step();
    chk("bp_hold_data2", 32'(out1_data), 32'h11);
    out1_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_second_data", 32'(out1_data), 32'h22);
    chk("bp_second_valid", 32'(out1_valid), 32'h1);
    step();
    chk("bp_drained", 32'(out1_valid), 32'h0);
    out1_ready = 1'b0;

    // Pass-through on channel 3
    in_sel = 2'd3; in_data = 8'h33; in_valid = 1'b1;
    step();
    chk("pt_first_data", 32'(out3_data), 32'h33);
    chk("pt_first_valid", 32'(out3_valid), 32'h1);
    in_data = 8'h44; out3_ready = 1'b1;
    #1;
    chk("pt_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out3_ready = 1'b0;
    chk("pt_valid_kept", 32'(out3_valid), 32'h1);
    chk("pt_new_data", 32'(out3_data), 32'h44);
    out3_ready = 1'b1;
    step();
    chk("pt_drained", 32'(out3_valid), 32'h0);
    out3_ready = 1'b0;

    // Independence: channel 0 stalled, channel 1 still accepts
    in_sel = 2'd0; in_data = 8'h66; in_valid = 1'b1;
    step();
    in_sel = 2'd1; in_data = 8'h55;
    #1;
    chk("ind_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("ind_ch1_data", 32'(out1_data), 32'h55);
    chk("ind_ch0_data", 32'(out0_data), 32'h66);
    chk("ind_valids", valids(), 32'h3);
    // Full, stalled channel must refuse a new word
    in_sel = 2'd0; in_data = 8'h77;
    #1;
    chk("ind_full_refuse", 32'(in_ready), 32'h0);
    step();
    chk("ind_no_overwrite", 32'(out0_data), 32'h66);
    // Ready on an empty channel has no effect
    in_valid = 1'b0; out2_ready = 1'b1;
    step();
    chk("ind_ready_empty", valids(), 32'h3);
    out2_ready = 1'b0;

    // Fill all four, then asynchronous reset mid-cycle
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h88;
    step();
    in_sel = 2'd3; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    chk("all_full", valids(), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valids", valids(), 32'h0);
    chk("async_rst_data", {out3_data, out2_data, out1_data, out0_data}, 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1; out3_ready = 1'b1;
    step();
    chk("post_rst2_valids", valids(), 32'h0);
    chk("post_rst2_in_ready", 32'(in_ready), 32'h1);
    out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;

`ifdef STREAM_DEMUX4_CNT_EN
    // 257 output handshakes on channel 0
    in_sel = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_ch0_valid", 32'(out0_valid), 32'h0);
    chk("cnt0_wrap", 32'(cnt0), 32'h1);
    chk("cnt_others", {8'h0, cnt3, cnt2, cnt1}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data bit width of input and each output channel.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  input word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts input word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  input word.
REQ-007 SHALL have port: in_sel  input  2  destination channel of the input word (0..3).
REQ-008 SHALL have ports: out0_valid..out3_valid  output  1 each  channel word present.
REQ-009 SHALL have ports: out0_ready..out3_ready  input  1 each  channel sink accepts word.
REQ-010 SHALL have ports: out0_data..out3_data  output  WIDTH each  channel word.

Function
REQ-011 SHALL contain one single-entry register buffer per channel, each with states EMPTY and FULL.
REQ-012 SHALL drive outN_valid high exactly while buffer N is FULL; outN_data SHALL be the buffer N contents.
REQ-013 SHALL drive in_ready = (buffer[in_sel] EMPTY) OR outN_ready for N = in_sel; this path is combinational.
REQ-014 SHALL accept an input handshake (in_valid AND in_ready) by loading in_data into buffer[in_sel] on that edge.
REQ-015 SHALL give a latency of exactly one cycle: a word accepted at edge k appears on outN_valid/outN_data after edge k.
REQ-016 SHALL complete an output handshake (outN_valid AND outN_ready) by setting buffer N to EMPTY, unless REQ-017 applies.
REQ-017 SHALL, on a simultaneous output handshake on N and input handshake to N, load the new word and keep buffer N FULL, with no bubble cycle.
REQ-018 SHALL hold outN_data and outN_valid stable while outN_valid is high and outN_ready is low.
REQ-019 SHALL never overwrite a FULL buffer that is not being drained in the same cycle.
REQ-020 SHALL let channels drain independently: a stalled channel SHALL NOT block input addressed to another channel.
REQ-021 SHALL sample in_sel only at the input handshake; in_sel and in_data MAY change while in_valid is low or in_ready is low.
REQ-022 SHALL ignore outN_ready while buffer N is EMPTY.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously set all buffers EMPTY, all outN_valid to 0 and all outN_data to 0.
REQ-024 SHALL discard any buffered word when rst_n is asserted mid-transfer; no word SHALL be delivered after reset release unless it is accepted again.
REQ-025 SHALL drive in_ready high during reset and after reset (all buffers EMPTY).

Configuration
REQ-026 SHALL, when macro STREAM_DEMUX4_CNT_EN is defined, add ports cnt0..cnt3 (output, 8 bits each), each counting output handshakes on its channel.
REQ-027 SHALL reset each counter to 0 asynchronously with rst_n, and SHALL wrap each counter from 255 to 0.
REQ-028 SHALL, without STREAM_DEMUX4_CNT_EN, omit the counter ports and logic; all other behaviour SHALL be identical.

Verification
REQ-029 Scenario basic route: in_sel=2, in_data=0xA5, in_valid=1, out2_ready=1 -> out2_valid=1 and out2_data=0xA5 one cycle later; other outN_valid=0.
REQ-030 Scenario backpressure: out1_ready=0, send 0x11 then 0x22 to channel 1 -> second cycle in_ready=0; out1_data holds 0x11 until out1_ready=1, then 0x22 follows on the next cycle.
REQ-031 Scenario pass-through: buffer 3 FULL with 0x33, out3_ready=1, input 0x44 to channel 3 in the same cycle -> in_ready=1; out3_data=0x44 next cycle with out3_valid continuously high.
REQ-032 Scenario independence: channel 0 stalled FULL, input 0x55 to channel 1 -> accepted; out1_data=0x55 next cycle; out0_data unchanged.
REQ-033 Scenario reset mid-operation: all four buffers FULL, rst_n pulsed low asynchronously -> all outN_valid=0 immediately; in_ready=1 after release.
REQ-034 Scenario counter (STREAM_DEMUX4_CNT_EN defined): 257 handshakes on channel 0 -> cnt0=1; cnt1..cnt3=0.
